// File: rtl/read_resp_unpacker.sv
// rtl/read_resp_unpacker.sv - serialises DRAM read-response words into a framed pixel stream
module read_resp_unpacker #(
    parameter int WORD_WIDTH  = 128,
    parameter int PIXEL_WIDTH = 16,
    parameter int FRAME_WORDS = 115200
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   valid_resp_in,
    input  logic [WORD_WIDTH-1:0]  data_resp_in,
    input  logic                   last_resp_in,
    output logic                   ready_resp_out,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   pixel_valid_out,
    input  logic                   pixel_ready_in,
    output logic                   pixel_first_out,
    output logic                   pixel_last_out,
    output logic                   frame_err_out
);

    localparam int PPW    = WORD_WIDTH / PIXEL_WIDTH;
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int CNT_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(PPW - 1);
    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(FRAME_WORDS - 1);

    logic [PPW-1:0][PIXEL_WIDTH-1:0] held_word;
    logic                            held_last;
    logic                            full;
    logic [LANE_W-1:0]               lane;
    logic                            first_pending;
    logic [CNT_W-1:0]                word_count;
    logic                            frame_err;

    logic pix_hs;
    logic at_last_lane;
    logic accept;
    logic at_frame_end;

    assign pix_hs       = full && pixel_ready_in;
    assign at_last_lane = (lane == LAST_LANE);
    assign at_frame_end = (word_count == LAST_COUNT);

    // Retiring the last lane frees the holding register in the same cycle,
    // so a waiting word lands with no bubble on the pixel stream.
    assign ready_resp_out = !full || (pix_hs && at_last_lane);
    assign accept         = valid_resp_in && ready_resp_out;

    assign pixel_valid_out = full;
    assign pixel_out       = held_word[lane];
    assign pixel_first_out = full && first_pending && (lane == '0);
    assign pixel_last_out  = full && held_last && at_last_lane;
    assign frame_err_out   = frame_err;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            held_word <= '0;
            held_last <= 1'b0;
            full      <= 1'b0;
            lane      <= '0;
        end else if (accept) begin
            held_word <= data_resp_in;
            held_last <= last_resp_in;
            full      <= 1'b1;
            lane      <= '0;
        end else if (pix_hs) begin
            if (at_last_lane) begin
                full <= 1'b0;
            end else begin
                lane <= lane + LANE_W'(1);
            end
        end
    end

    // Set wins over clear so a one-pixel frame still re-arms the first marker.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            first_pending <= 1'b1;
        end else if (pix_hs && pixel_last_out) begin
            first_pending <= 1'b1;
        end else if (pix_hs && pixel_first_out) begin
            first_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            word_count <= '0;
            frame_err  <= 1'b0;
        end else if (accept) begin
            if (last_resp_in || at_frame_end) begin
                word_count <= '0;
            end else begin
                word_count <= word_count + CNT_W'(1);
            end
            if (last_resp_in != at_frame_end) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule
